// File: rtl/button_debounce_rx.sv
// Board-input conditioner: synchronises and debounces a raw pin, then reports the
// clean level, edge strobes, a wrapping press count and a long-press strobe.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RELEASED | level low (or just risen); hold timer cleared
//   PRESSED  | level high; hold timer running toward the long-press point
//   HELD     | long press already reported; timer frozen until release
module button_debounce_rx #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_raw,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] press_count,
    output logic             long_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_TC  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_TC = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_in;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   long_q, long_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    state_t                 state_q, state_d;

    assign s_in = sync_q[SYNC_STAGES-1];

    // Any cycle where the synchronised input agrees with the level restarts the count.
    always_comb begin
        dcnt_d  = dcnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s_in == level_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DEB_TC) begin
            dcnt_d  = '0;
            level_d = ~level_q;
            rise_d  = ~level_q;
            fall_d  = level_q;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
        count_d = rise_d ? count_q + 1'b1 : count_q;
    end

    // The FSM reacts to the edge decision itself so long_press lands LONG_CYCLES after rise_pulse.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        long_d  = 1'b0;
        case (state_q)
            RELEASED: begin
                hcnt_d = '0;
                if (rise_d) begin
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (hcnt_q == HOLD_TC) begin
                    long_d  = 1'b1;
                    state_d = HELD;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
                if (fall_d) begin
                    state_d = RELEASED;
                    hcnt_d  = '0;
                end
            end
            HELD: begin
                if (fall_d) begin
                    state_d = RELEASED;
                    hcnt_d  = '0;
                end
            end
            default: begin
                state_d = RELEASED;
                hcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            dcnt_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            long_q  <= 1'b0;
            count_q <= '0;
            hcnt_q  <= '0;
            state_q <= RELEASED;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_raw};
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            long_q  <= long_d;
            count_q <= count_d;
            hcnt_q  <= hcnt_d;
            state_q <= state_d;
        end
    end

    assign level_out   = level_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign press_count = count_q;
    assign long_press  = long_q;

endmodule
